mem_bus_arbiter: RTL and testbench

Shares the single-port system RAM between the Z80 CPU core and the video fetch unit. Serializes their accesses through a three-phase memory sequencer, stalls the CPU via `cpu_wait_n` while the memory is busy or video holds priority, and bounds video starvation of the CPU. It also owns the boot-time address relocation that maps CPU fetches to the top 16 KiB until the first I/O cycle. It sits between the CPU/video masters and the memory module.

---
 rtl/cobra_bus_pkg.sv | 18 +
 rtl/boot_reloc.sv | 31 +++
 rtl/mem_bus_arbiter.sv | 171 +++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cobra_bus_pkg.sv
// Shared types and constants for the Cobra system bus blocks.
package cobra_bus_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_CMD  = 2'd1,
        ARB_DATA = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_VID = 1'b1
    } arb_owner_t;

    // Boot image lives in the top 16 KiB of the 64 KiB space.
    localparam logic [15:0] RELOC_MASK_DEFAULT = 16'hC000;

endpackage

// File: rtl/boot_reloc.sv
// Boot-time relocation: CPU addresses are ORed with a mask until the
// first I/O cycle, after which they pass through unchanged until reset.
module boot_reloc
    import cobra_bus_pkg::*;
#(
    parameter int              AW         = 16,
    parameter logic [AW-1:0]   RELOC_MASK = AW'(RELOC_MASK_DEFAULT)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          iorq,
    input  logic [AW-1:0] addr_in,
    output logic [AW-1:0] addr_out,
    output logic          reloc_en
);

    logic reloc_en_reg;

    // One-shot disarm: the first I/O cycle turns relocation off for good.
    always_ff @(posedge clk) begin
        if (reset) begin
            reloc_en_reg <= 1'b1;
        end else if (iorq) begin
            reloc_en_reg <= 1'b0;
        end
    end

    assign reloc_en = reloc_en_reg;
    assign addr_out = reloc_en_reg ? (addr_in | RELOC_MASK) : addr_in;

endmodule

// File: rtl/mem_bus_arbiter.sv
// CPU / video arbiter for the single-port system RAM.
// Three-phase sequencer (IDLE grant, CMD strobe, DATA completion) with
// bounded video bursts while the CPU waits. Boot relocation of CPU
// addresses is built in only when ARB_BOOT_RELOC_EN is defined.
module mem_bus_arbiter
    import cobra_bus_pkg::*;
#(
    parameter int            AW            = 16,
    parameter int            DW            = 8,
    parameter int            VID_MAX_BURST = 4,
    parameter logic [AW-1:0] RELOC_MASK    = AW'(RELOC_MASK_DEFAULT)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_mreq,
    input  logic          cpu_rd,
    input  logic          cpu_wr,
    input  logic          cpu_iorq,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_wait_n,
    input  logic          vid_req,
    input  logic [AW-1:0] vid_addr,
    output logic          vid_ack,
    output logic          vid_rvalid,
    output logic [DW-1:0] vid_rdata,
    output logic          mem_mreq,
    output logic          mem_rd,
    output logic          mem_wr,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    input  logic [DW-1:0] mem_dout
);

    localparam logic [3:0] BURST_MAX = 4'(VID_MAX_BURST);

    arb_state_t    state_reg, state_next;
    arb_owner_t    owner_reg;
    logic [AW-1:0] addr_reg;
    logic [DW-1:0] wdata_reg;
    logic          wr_reg;
    logic          mem_mreq_reg, mem_rd_reg, mem_wr_reg;
    logic          cpu_served_reg;
    logic [3:0]    burst_cnt_reg, burst_cnt_next;
    logic          vid_rvalid_reg;
    logic [DW-1:0] vid_rdata_reg;
    logic [DW-1:0] cpu_rdata_reg;

    logic          cpu_pending;
    logic          burst_full;
    logic          grant_cpu, grant_vid;
    logic          cpu_data_cycle;
    logic [AW-1:0] cpu_addr_eff;

`ifdef ARB_BOOT_RELOC_EN
    logic reloc_en;

    boot_reloc #(
        .AW         (AW),
        .RELOC_MASK (RELOC_MASK)
    ) u_boot_reloc (
        .clk      (clk),
        .reset    (reset),
        .iorq     (cpu_iorq),
        .addr_in  (cpu_addr),
        .addr_out (cpu_addr_eff),
        .reloc_en (reloc_en)
    );
`else
    // Relocation absent: CPU address passes straight through.
    logic unused_reloc;
    assign unused_reloc = ^{cpu_iorq, RELOC_MASK};
    assign cpu_addr_eff = cpu_addr;
`endif

    assign cpu_pending    = cpu_mreq & (cpu_rd | cpu_wr) & ~cpu_served_reg;
    assign burst_full     = (burst_cnt_reg == BURST_MAX);
    assign cpu_data_cycle = (state_reg == ARB_DATA) && (owner_reg == OWN_CPU);

    // Next-state and grant decision; grants are only made from IDLE.
    always_comb begin
        state_next = state_reg;
        grant_cpu  = 1'b0;
        grant_vid  = 1'b0;
        case (state_reg)
            ARB_IDLE: begin
                if (vid_req && !(cpu_pending && burst_full)) begin
                    grant_vid  = 1'b1;
                    state_next = ARB_CMD;
                end else if (cpu_pending) begin
                    grant_cpu  = 1'b1;
                    state_next = ARB_CMD;
                end
            end
            ARB_CMD:  state_next = ARB_DATA;
            ARB_DATA: state_next = ARB_IDLE;
            default:  state_next = ARB_IDLE;
        endcase
    end

    // Starvation counter: counts video wins only while the CPU is waiting.
    always_comb begin
        burst_cnt_next = burst_cnt_reg;
        if (!cpu_pending || grant_cpu) begin
            burst_cnt_next = 4'd0;
        end else if (grant_vid && !burst_full) begin
            burst_cnt_next = burst_cnt_reg + 4'd1;
        end
    end

    // Sequencer state, latched transfer, strobes and read-data capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= ARB_IDLE;
            owner_reg      <= OWN_CPU;
            addr_reg       <= '0;
            wdata_reg      <= '0;
            wr_reg         <= 1'b0;
            mem_mreq_reg   <= 1'b0;
            mem_rd_reg     <= 1'b0;
            mem_wr_reg     <= 1'b0;
            cpu_served_reg <= 1'b0;
            burst_cnt_reg  <= 4'd0;
            vid_rvalid_reg <= 1'b0;
            vid_rdata_reg  <= '0;
            cpu_rdata_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            burst_cnt_reg <= burst_cnt_next;
            // Served flag holds off a second access for the same mreq.
            cpu_served_reg <= cpu_mreq & (cpu_served_reg | cpu_data_cycle);

            mem_mreq_reg <= grant_cpu | grant_vid;
            mem_rd_reg   <= grant_vid | (grant_cpu & ~cpu_wr);
            mem_wr_reg   <= grant_cpu & cpu_wr;

            if (grant_vid) begin
                owner_reg <= OWN_VID;
                addr_reg  <= vid_addr;
                wdata_reg <= '0;
                wr_reg    <= 1'b0;
            end else if (grant_cpu) begin
                owner_reg <= OWN_CPU;
                addr_reg  <= cpu_addr_eff;
                wdata_reg <= cpu_wdata;
                wr_reg    <= cpu_wr;
            end

            vid_rvalid_reg <= (state_reg == ARB_DATA) && (owner_reg == OWN_VID);
            if ((state_reg == ARB_DATA) && (owner_reg == OWN_VID)) begin
                vid_rdata_reg <= mem_dout;
            end
            if (cpu_data_cycle && !wr_reg) begin
                cpu_rdata_reg <= mem_dout;
            end
        end
    end

    assign mem_mreq   = mem_mreq_reg;
    assign mem_rd     = mem_rd_reg;
    assign mem_wr     = mem_wr_reg;
    assign mem_addr   = addr_reg;
    assign mem_din    = wdata_reg;
    assign vid_ack    = grant_vid & ~reset;
    assign vid_rvalid = vid_rvalid_reg;
    assign vid_rdata  = vid_rdata_reg;
    assign cpu_rdata  = cpu_data_cycle ? mem_dout : cpu_rdata_reg;
    assign cpu_wait_n = reset | ~cpu_pending | cpu_data_cycle;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter. Inputs change on the falling edge,
// outputs are sampled 1 ns later. Expected boot addresses follow
// ARB_BOOT_RELOC_EN when it is defined for the build.
module tb_mem_bus_arbiter;

`ifdef ARB_BOOT_RELOC_EN
    localparam logic [15:0] BOOT_OR = 16'hC000;
`else
    localparam logic [15:0] BOOT_OR = 16'h0000;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_mreq = 1'b0, cpu_rd = 1'b0, cpu_wr = 1'b0, cpu_iorq = 1'b0;
    logic [15:0] cpu_addr = '0;
    logic [7:0]  cpu_wdata = '0;
    logic [7:0]  cpu_rdata;
    logic        cpu_wait_n;
    logic        vid_req = 1'b0;
    logic [15:0] vid_addr = '0;
    logic        vid_ack, vid_rvalid;
    logic [7:0]  vid_rdata;
    logic        mem_mreq, mem_rd, mem_wr;
    logic [15:0] mem_addr;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout = '0;

    int vectors = 0;
    int miscompares = 0;
    int wr_count = 0;
    logic [7:0] last_wr_data = '0;
    logic [15:0] last_wr_addr = '0;

    always #5 clk = ~clk;

    mem_bus_arbiter #(
        .AW(16), .DW(8), .VID_MAX_BURST(4), .RELOC_MASK(16'hC000)
    ) dut (
        .clk(clk), .reset(reset),
        .cpu_mreq(cpu_mreq), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_iorq(cpu_iorq),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
        .cpu_wait_n(cpu_wait_n),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack),
        .vid_rvalid(vid_rvalid), .vid_rdata(vid_rdata),
        .mem_mreq(mem_mreq), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
    );

    // Memory contents are a fixed function of address; C000 holds A5.
    function automatic logic [7:0] model_byte(input logic [15:0] a);
        return a[15:8] ^ a[7:0] ^ 8'h65;
    endfunction

    // RAM model: read data one cycle after mem_rd, writes are logged.
    always @(posedge clk) begin
        if (mem_mreq && mem_rd) mem_dout <= model_byte(mem_addr);
        if (mem_mreq && mem_wr) begin
            wr_count     <= wr_count + 1;
            last_wr_addr <= mem_addr;
            last_wr_data <= mem_din;
        end
    end

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        vectors++;
        if ({mem_mreq, mem_rd, mem_wr} !== 3'b000) begin
            $display("FAIL reset_strobes: got %b required 000", {mem_mreq, mem_rd, mem_wr});
            miscompares++;
        end
        vectors++;
        if ({vid_ack, vid_rvalid, vid_rdata, cpu_rdata} !== 18'h0) begin
            $display("FAIL reset_outputs: got ack=%b rvalid=%b vdata=%h cdata=%h required zeros",
                     vid_ack, vid_rvalid, vid_rdata, cpu_rdata);
            miscompares++;
        end
        vectors++;
        if (cpu_wait_n !== 1'b1) begin
            $display("FAIL reset_wait_n: got %b required 1", cpu_wait_n);
            miscompares++;
        end
        @(negedge clk);
        reset = 1'b0;
        $display("txn reset released");
    endtask

    // CPU read from idle bus: 2-cycle stall, strobe in CMD, data in DATA.
    task automatic test_cpu_read(input string tag, input logic [15:0] a,
                                 input logic [15:0] exp_addr);
        @(negedge clk);
        cpu_mreq = 1'b1; cpu_rd = 1'b1; cpu_addr = a;
        #1;
        vectors++;
        if (cpu_wait_n !== 1'b0) begin
            $display("FAIL %s_stall_grant: got %b required 0", tag, cpu_wait_n);
            miscompares++;
        end
        @(negedge clk); #1;
        vectors++;
        if ({mem_mreq, mem_rd, mem_wr, cpu_wait_n} !== 4'b1100) begin
            $display("FAIL %s_cmd: got mreq/rd/wr/wait_n=%b required 1100",
                     tag, {mem_mreq, mem_rd, mem_wr, cpu_wait_n});
            miscompares++;
        end
        vectors++;
        if (mem_addr !== exp_addr) begin
            $display("FAIL %s_addr: got %h required %h", tag, mem_addr, exp_addr);
            miscompares++;
        end
        @(negedge clk); #1;
        vectors++;
        if (cpu_wait_n !== 1'b1 || cpu_rdata !== model_byte(exp_addr)) begin
            $display("FAIL %s_data: got wait_n=%b rdata=%h required 1 %h",
                     tag, cpu_wait_n, cpu_rdata, model_byte(exp_addr));
            miscompares++;
        end
        @(negedge clk); #1;
        vectors++;
        if (mem_mreq !== 1'b0 || cpu_wait_n !== 1'b1) begin
            $display("FAIL %s_single: got mreq=%b wait_n=%b required 0 1", tag, mem_mreq, cpu_wait_n);
            miscompares++;
        end
        @(negedge clk);
        cpu_mreq = 1'b0; cpu_rd = 1'b0;
        #1;
        vectors++;
        if (cpu_rdata !== model_byte(exp_addr)) begin
            $display("FAIL %s_hold: got %h required %h", tag, cpu_rdata, model_byte(exp_addr));
            miscompares++;
        end
        $display("txn cpu read %s addr=%h mem_addr=%h data=%h", tag, a, exp_addr, cpu_rdata);
    endtask

    task automatic test_iorq();
        @(negedge clk); cpu_iorq = 1'b1;
        @(negedge clk); cpu_iorq = 1'b0;
        $display("txn io cycle");
    endtask

    task automatic test_vid_read();
        @(negedge clk);
        vid_req = 1'b1; vid_addr = 16'h4000;
        #1;
        vectors++;
        if (vid_ack !== 1'b1) begin
            $display("FAIL vid_ack: got %b required 1", vid_ack);
            miscompares++;
        end
        @(negedge clk);
        vid_req = 1'b0;
        #1;
        vectors++;
        if ({vid_ack, mem_mreq, mem_rd, mem_wr} !== 4'b0110 || mem_addr !== 16'h4000) begin
            $display("FAIL vid_cmd: got ack/mreq/rd/wr=%b addr=%h required 0110 4000",
                     {vid_ack, mem_mreq, mem_rd, mem_wr}, mem_addr);
            miscompares++;
        end
        @(negedge clk); #1;
        vectors++;
        if (vid_rvalid !== 1'b0) begin
            $display("FAIL vid_rvalid_early: got %b required 0", vid_rvalid);
            miscompares++;
        end
        @(negedge clk); #1;
        vectors++;
        if (vid_rvalid !== 1'b1 || vid_rdata !== model_byte(16'h4000)) begin
            $display("FAIL vid_rvalid: got %b data=%h required 1 %h",
                     vid_rvalid, vid_rdata, model_byte(16'h4000));
            miscompares++;
        end
        @(negedge clk); #1;
        vectors++;
        if (vid_rvalid !== 1'b0) begin
            $display("FAIL vid_rvalid_pulse: got %b required 0", vid_rvalid);
            miscompares++;
        end
        $display("txn video read addr=4000 data=%h", vid_rdata);
    endtask

    // Video held high with CPU pending: count video wins before the CPU.
    task automatic test_burst(input string tag, input logic [15:0] a);
        int  acks = 0;
        bit  done = 1'b0;
        @(negedge clk);
        vid_req = 1'b1; vid_addr = 16'h4000;
        cpu_mreq = 1'b1; cpu_rd = 1'b1; cpu_addr = a;
        for (int c = 0; c < 60 && !done; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            if (vid_ack) acks++;
            if (cpu_wait_n) begin
                done = 1'b1;
                vectors++;
                if (cpu_rdata !== model_byte(a)) begin
                    $display("FAIL %s_data: got %h required %h", tag, cpu_rdata, model_byte(a));
                    miscompares++;
                end
            end
        end
        vectors++;
        if (!done) begin
            $display("FAIL %s_timeout: got no CPU grant in 60 cycles required grant", tag);
            miscompares++;
        end
        vectors++;
        if (acks != 4) begin
            $display("FAIL %s_count: got %0d video grants required 4", tag, acks);
            miscompares++;
        end
        @(negedge clk);
        cpu_mreq = 1'b0; cpu_rd = 1'b0;
        $display("txn burst %s video grants=%0d cpu data=%h", tag, acks, cpu_rdata);
    endtask

    task automatic test_write_mid_video();
        int wc0;
        @(negedge clk);
        vid_req = 1'b1; vid_addr = 16'h5000;
        #1;
        vectors++;
        if (vid_ack !== 1'b1) begin
            $display("FAIL wr_vid_ack: got %b required 1", vid_ack);
            miscompares++;
        end
        @(negedge clk);
        vid_req = 1'b0;
        cpu_mreq = 1'b1; cpu_wr = 1'b1; cpu_addr = 16'h1234; cpu_wdata = 8'h3C;
        wc0 = wr_count;
        #1;
        vectors++;
        if (cpu_wait_n !== 1'b0 || mem_rd !== 1'b1) begin
            $display("FAIL wr_during_vid: got wait_n=%b rd=%b required 0 1", cpu_wait_n, mem_rd);
            miscompares++;
        end
        @(negedge clk); #1;
        @(negedge clk); #1;
        vectors++;
        if (mem_wr !== 1'b0 || cpu_wait_n !== 1'b0) begin
            $display("FAIL wr_grant: got wr=%b wait_n=%b required 0 0", mem_wr, cpu_wait_n);
            miscompares++;
        end
        @(negedge clk); #1;
        vectors++;
        if ({mem_mreq, mem_rd, mem_wr} !== 3'b101 || mem_din !== 8'h3C || mem_addr !== 16'h1234) begin
            $display("FAIL wr_cmd: got strobes=%b din=%h addr=%h required 101 3c 1234",
                     {mem_mreq, mem_rd, mem_wr}, mem_din, mem_addr);
            miscompares++;
        end
        @(negedge clk); #1;
        vectors++;
        if (cpu_wait_n !== 1'b1) begin
            $display("FAIL wr_release: got %b required 1", cpu_wait_n);
            miscompares++;
        end
        repeat (3) @(negedge clk);
        cpu_mreq = 1'b0; cpu_wr = 1'b0;
        #1;
        vectors++;
        if (wr_count - wc0 != 1 || last_wr_data !== 8'h3C || last_wr_addr !== 16'h1234) begin
            $display("FAIL wr_single: got %0d writes data=%h addr=%h required 1 3c 1234",
                     wr_count - wc0, last_wr_data, last_wr_addr);
            miscompares++;
        end
        $display("txn cpu write addr=1234 data=3c writes=%0d", wr_count - wc0);
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        cpu_mreq = 1'b1; cpu_rd = 1'b1; cpu_addr = 16'h0030;
        @(negedge clk); #1;
        vectors++;
        if (mem_mreq !== 1'b1) begin
            $display("FAIL rst_mid_cmd: got %b required 1", mem_mreq);
            miscompares++;
        end
        reset = 1'b1;
        @(negedge clk); #1;
        vectors++;
        if ({mem_mreq, mem_rd, mem_wr, cpu_wait_n, vid_ack} !== 5'b00010 || cpu_rdata !== 8'h00) begin
            $display("FAIL rst_mid_drop: got strobes/wait_n/ack=%b rdata=%h required 00010 00",
                     {mem_mreq, mem_rd, mem_wr, cpu_wait_n, vid_ack}, cpu_rdata);
            miscompares++;
        end
        reset = 1'b0; cpu_mreq = 1'b0; cpu_rd = 1'b0;
        @(negedge clk);
        vid_req = 1'b1; vid_addr = 16'h4000;
        #1;
        vectors++;
        if (vid_ack !== 1'b1) begin
            $display("FAIL rst_mid_idle: got ack=%b required 1", vid_ack);
            miscompares++;
        end
        @(negedge clk);
        vid_req = 1'b0;
        repeat (3) @(negedge clk);
        $display("txn reset during CMD");
        test_cpu_read("rearm", 16'h0000, BOOT_OR);
    endtask

    initial begin
        test_reset();
        test_cpu_read("boot", 16'h0000, BOOT_OR);
        test_iorq();
        test_cpu_read("post_io", 16'h0010, 16'h0010);
        test_vid_read();
        test_burst("first", 16'h0020);
        test_burst("second", 16'h0021);
        vid_req = 1'b0;
        repeat (4) @(negedge clk);
        test_write_mid_video();
        repeat (2) @(negedge clk);
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion by 200000 ns required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
